// File: rtl/nlc_adc_feeder.sv
// rtl/nlc_adc_feeder.sv - FIFO-buffered srdyi/x_adc sample feeder for the 1-channel NLC
module nlc_adc_feeder #(
  parameter int DATA_W  = 21,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              srdyo,
  input  logic              clr_err,
  output logic              srdyi,
  output logic [DATA_W-1:0] x_adc,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic [7:0]        drop_cnt,
  output logic              timeout_err
);

  localparam int              CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  wait_cnt;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;
  logic to_hit;

  // A pop only happens from IDLE, so a full FIFO can still accept a sample
  // in the very cycle its head is handed to the NLC.
  assign full   = (fifo_count == FULL_CNT);
  assign empty  = (fifo_count == '0);
  assign pop    = (state == S_IDLE) && !empty;
  assign push   = adc_valid && (!full || pop);
  assign drop   = adc_valid && full && !pop;
  assign to_hit = (state == S_WAIT) && !srdyo && (wait_cnt == WAIT_LAST);

  // Sample storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Error reporting; a clear always beats a same-cycle drop or timeout.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (clr_err) begin
      drop_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  // Issue/handshake sequencer: one sample in flight until srdyo or timeout.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state    <= S_IDLE;
      srdyi    <= 1'b0;
      x_adc    <= '0;
      busy     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            x_adc <= mem[rd_ptr];
            srdyi <= 1'b1;
            busy  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          srdyi    <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (srdyo || (wait_cnt == WAIT_LAST)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          srdyi <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nlc_adc_feeder.sv
// tb/tb_nlc_adc_feeder.sv - self-checking bench for nlc_adc_feeder
module tb_nlc_adc_feeder;

  localparam int DATA_W  = 21;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              GlobalReset;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              srdyo;
  logic              clr_err;
  logic              srdyi;
  logic [DATA_W-1:0] x_adc;
  logic              busy;
  logic [ADDR_W:0]   fifo_count;
  logic [7:0]        drop_cnt;
  logic              timeout_err;

  nlc_adc_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .adc_valid(adc_valid), .adc_data(adc_data),
    .srdyo(srdyo), .clr_err(clr_err), .srdyi(srdyi), .x_adc(x_adc), .busy(busy),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of pending samples plus the cycle index at which
  // the in-flight sample was handed over.
  logic [DATA_W-1:0] q[$];
  bit                m_busy;
  int                cyc;
  int                m_issue;
  logic [DATA_W-1:0] m_x;
  int                m_drop;
  bit                m_terr;

  // NLC responder
  int resp_cd;
  int resp_delay;
  bit resp_en;
  bit resp_rand;
  bit spur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 0;
    m_issue = 0;
    m_x     = '0;
    m_drop  = 0;
    m_terr  = 0;
    resp_cd = 0;
  endtask

  task automatic tick();
    bit to_now;
    bit drop_now;
    @(posedge clk);
    cyc++;
    to_now   = 0;
    drop_now = 0;
    if (!m_busy && q.size() > 0) begin
      m_x     = q.pop_front();
      m_busy  = 1;
      m_issue = cyc;
    end else if (m_busy && (cyc - m_issue) >= 2) begin
      if (srdyo) m_busy = 0;
      else if ((cyc - m_issue) == TIMEOUT + 1) begin
        m_busy = 0;
        to_now = 1;
      end
    end
    if (adc_valid) begin
      if (q.size() < DEPTH) q.push_back(adc_data);
      else drop_now = 1;
    end
    if (clr_err) begin
      m_drop = 0;
      m_terr = 0;
    end else begin
      if (drop_now && m_drop < 255) m_drop++;
      if (to_now) m_terr = 1;
    end
    #1;
    chk("srdyi", {31'd0, srdyi}, {31'd0, (m_busy && cyc == m_issue)});
    chk("x_adc", {11'd0, x_adc}, {11'd0, m_x});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("fifo_count", {28'd0, fifo_count}, q.size());
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    srdyo = (resp_cd == 1);
    if (resp_cd > 0) resp_cd--;
    if (resp_en && m_busy && cyc == m_issue) begin
      if (resp_rand) resp_cd = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      else resp_cd = resp_delay;
    end
    if (spur && $urandom_range(0, 99) < 3) srdyo = 1'b1;
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    adc_valid = v;
    adc_data  = d;
    tick();
  endtask

  initial begin
    int pulses;
    int peak;
    GlobalReset = 1'b0;
    adc_valid   = 1'b0;
    adc_data    = '0;
    srdyo       = 1'b0;
    clr_err     = 1'b0;
    resp_en     = 0;
    resp_rand   = 0;
    spur        = 0;
    resp_delay  = 0;
    cyc         = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_srdyi", {31'd0, srdyi}, 0);
    chk("rst_x_adc", {11'd0, x_adc}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fifo_count", {28'd0, fifo_count}, 0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    GlobalReset = 1'b1;

    // Single sample, response 20 cycles later
    resp_en    = 1;
    resp_delay = 20;
    step(1'b1, 21'h000123);
    step(1'b0, '0);
    chk("t1_srdyi_rise", {31'd0, srdyi}, 1);
    chk("t1_x_adc", {11'd0, x_adc}, 32'h123);
    step(1'b0, '0);
    chk("t1_srdyi_one_cycle", {31'd0, srdyi}, 0);
    for (int i = 0; i < 40 && busy; i++) step(1'b0, '0);
    chk("t1_busy_done", {31'd0, busy}, 0);

    // Burst of five, response 15 cycles after each issue
    resp_delay = 15;
    pulses     = 0;
    peak       = 0;
    for (int i = 0; i < 200 && !(i >= 5 && pulses == 5 && !busy); i++) begin
      step(i < 5, (i < 5) ? DATA_W'(i + 1) : '0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (srdyi) begin
        chk("t2_x_order", {11'd0, x_adc}, pulses + 1);
        pulses++;
      end
    end
    chk("t2_pulses", pulses, 5);
    chk("t2_peak", peak, 4);
    chk("t2_drop", {24'd0, drop_cnt}, 0);

    // Overflow with no response, then timeout
    resp_en = 0;
    for (int i = 0; i < 12; i++) step(1'b1, DATA_W'(32'h100 + i));
    adc_valid = 1'b0;
    chk("t3_drop", {24'd0, drop_cnt}, 3);
    chk("t3_full", {28'd0, fifo_count}, DEPTH);
    for (int i = 0; i < 100 && !m_terr; i++) step(1'b0, '0);
    chk("t3_timeout_err", {31'd0, timeout_err}, 1);

    // Full FIFO with a push coinciding with the IDLE pop
    resp_en    = 1;
    resp_delay = 3;
    step(1'b1, 21'h1AB);
    chk("t4_srdyi", {31'd0, srdyi}, 1);
    chk("t4_count", {28'd0, fifo_count}, DEPTH);
    chk("t4_drop", {24'd0, drop_cnt}, 3);
    for (int i = 0; i < 200 && (q.size() > 0 || m_busy); i++) step(1'b0, '0);
    chk("t4_drained", {28'd0, fifo_count}, 0);

    // Stray srdyo in IDLE, then clear with a simultaneous drop
    srdyo = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t5_idle_srdyi", {31'd0, srdyi}, 0);
    chk("t5_idle_busy", {31'd0, busy}, 0);
    resp_en = 0;
    for (int i = 0; i < 9; i++) step(1'b1, DATA_W'(32'h200 + i));
    clr_err = 1'b1;
    step(1'b1, 21'h2FF);
    clr_err = 1'b0;
    chk("t5_clr_drop", {24'd0, drop_cnt}, 0);
    chk("t5_clr_terr", {31'd0, timeout_err}, 0);
    chk("t5_count", {28'd0, fifo_count}, DEPTH);

    // Drain, queue three behind an in-flight sample, reset mid-WAIT
    resp_en = 1;
    for (int i = 0; i < 200 && (q.size() > 0 || m_busy); i++) step(1'b0, '0);
    resp_en = 0;
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(32'h300 + i));
    step(1'b0, '0);
    step(1'b0, '0);
    chk("t6_pre_count", {28'd0, fifo_count}, 3);
    chk("t6_pre_busy", {31'd0, busy}, 1);
    #3;
    GlobalReset = 1'b0;
    #1;
    chk("t6_async_x_adc", {11'd0, x_adc}, 0);
    chk("t6_async_busy", {31'd0, busy}, 0);
    chk("t6_async_srdyi", {31'd0, srdyi}, 0);
    chk("t6_async_count", {28'd0, fifo_count}, 0);
    model_reset();
    srdyo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    GlobalReset = 1'b1;
    step(1'b0, '0);
    chk("t6_post_count", {28'd0, fifo_count}, 0);

    // Randomized traffic against the model
    resp_en   = 1;
    resp_rand = 1;
    spur      = 1;
    for (int i = 0; i < 600; i++) begin
      clr_err = ($urandom_range(0, 99) < 2);
      step($urandom_range(0, 99) < 45, DATA_W'($urandom));
    end
    clr_err = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nlc_adc_feeder.md
Name: nlc_adc_feeder

Overview:
- Transmit side of the srdyi/x_adc sample interface into the 1-channel NLC.
- Buffers raw ADC samples in a small FIFO and issues one srdyi pulse with the matching x_adc word per conversion.
- Issues the next sample only after the NLC returns srdyo, so the multi-cycle Horner evaluation never sees a second sample mid-computation.
- Reports FIFO-overflow drops and NLC-response timeouts.

Parameters:
DATA_W, 21, width of ADC sample / x_adc
DEPTH, 8, FIFO entries (power of 2, >= 2)
ADDR_W, 3, log2(DEPTH)
TIMEOUT, 64, max cycles in WAIT before srdyo must arrive

Ports:
clk  in  1  system clock, rising edge
GlobalReset  in  1  asynchronous, active-low reset
adc_valid  in  1  ADC sample strobe, one sample per high cycle
adc_data  in  DATA_W  ADC sample, two's complement
srdyo  in  1  NLC done pulse (x_lin valid)
clr_err  in  1  synchronous clear of drop_cnt and timeout_err
srdyi  out  1  one-cycle start pulse to NLC
x_adc  out  DATA_W  sample presented to NLC
busy  out  1  high in ISSUE or WAIT
fifo_count  out  ADDR_W+1  current FIFO occupancy
drop_cnt  out  8  samples dropped on full FIFO, saturating
timeout_err  out  1  sticky, set on WAIT timeout

Behaviour:
- Reset (GlobalReset=0, asynchronous):
  - state=IDLE; FIFO empty; fifo_count=0.
  - srdyi=0, x_adc=0, busy=0, drop_cnt=0, timeout_err=0, wait counter=0.
- FIFO:
  - Push when adc_valid=1 and (not full, or pop in the same cycle).
  - Full, adc_valid=1, no pop: sample discarded; drop_cnt+1, saturating at 255.
  - Pointers wrap modulo DEPTH.
  - fifo_count updates on the edge after the push/pop; simultaneous push+pop leaves it unchanged.
- FSM, all outputs registered:
  - IDLE: if FIFO non-empty, pop head into x_adc, srdyi<=1, go to ISSUE.
  - ISSUE (1 cycle): srdyi=1; next edge srdyi<=0, wait counter<=0, go to WAIT.
  - WAIT:
    - srdyo=1: go to IDLE.
    - Otherwise the wait counter increments; on reaching TIMEOUT-1 without srdyo, timeout_err<=1 and go to IDLE.
- Latency:
  - adc_valid sampled at edge k into an empty FIFO with FSM in IDLE → srdyi high in the cycle after edge k+1.
  - Back-to-back: srdyo sampled at edge m with FIFO non-empty → srdyi high after edge m+1. Minimum 2-cycle gap between srdyi pulses plus NLC latency.
- x_adc holds its value from the pop until the next pop; it never changes during WAIT.
- srdyo outside WAIT is ignored and does not set errors.
- clr_err=1: drop_cnt<=0, timeout_err<=0. Clear wins over a same-cycle drop increment or timeout set.
- busy = (state != IDLE).
- Reset mid-WAIT or mid-ISSUE: everything returns to reset values, queued samples are lost, and srdyi deasserts immediately.

Test Plan:
- Reset, then single sample adc_data=21'h000123 → srdyi pulses exactly one cycle, two edges after adc_valid, with x_adc=21'h000123. srdyo returned 20 cycles later → busy falls one cycle after srdyo.
- Burst of 5 samples 1..5 on consecutive cycles, srdyo returned 15 cycles after each srdyi → five srdyi pulses in order, x_adc=1,2,3,4,5; fifo_count peaks at 4; drop_cnt=0.
- With srdyo held low, push 12 samples → first sample issued, FIFO fills to 8, drop_cnt=3. After TIMEOUT=64 cycles in WAIT → timeout_err=1 and the next sample issues.
- Full FIFO with adc_valid coinciding with an IDLE pop → sample accepted, fifo_count stays 8, drop_cnt unchanged.
- srdyo pulsed while in IDLE with an empty FIFO → no state change, no srdyi. Then clr_err with a simultaneous drop → drop_cnt=0.
- Assert GlobalReset low during WAIT with 3 samples queued → all outputs return to 0 asynchronously, and fifo_count=0 after release.
